// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset/bubble constants,
// fetch FSM state encoding (also used for debug by the hazard unit), IF/ID payload.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_WAIT = WAIT,
        ST_HOLD = HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, inject a bubble, or hold.
// Load has priority over bubble; with neither asserted the register holds.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_ir,
    input  logic [31:0] load_pc4,
    output if_id_t      q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.ir    <= NOP_INSTR;
            q.pc4   <= RESET_PC;
            q.valid <= 1'b0;
        end else if (load) begin
            q.ir    <= load_ir;
            q.pc4   <= load_pc4;
            q.valid <= 1'b1;
        end else if (bubble) begin
            // pc4 is kept so D still sees a sensible link value behind the bubble
            q.ir    <= NOP_INSTR;
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register and instruction-fetch sequencer for the 5-stage pipeline.
// Handshake: a request is outstanding while imem_req=1; imem_addr is held until the cycle imem_ack=1, which completes it.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] ir_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic [1:0]  dbg_state,
    output logic        dbg_pend_valid
);

    fetch_state_e state, state_nx;

    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] fbuf;

    logic        complete;
    logic        bubble;
    logic        fbuf_we;
    logic        redirect_acc;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] fetch_word;
    if_id_t      if_id;

    assign target       = word_align(npc_in);
    // Stalled redirects are dropped; D re-presents them once it advances.
    assign redirect_acc = redirect && valid_d && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        complete = 1'b0;
        bubble   = 1'b0;
        fbuf_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack && !stall) begin
                    complete = 1'b1;
                end else if (imem_ack) begin
                    fbuf_we  = 1'b1;
                    state_nx = ST_HOLD;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    complete = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // The fetch completing alongside an accepted redirect is the delay slot,
    // so the redirect target bypasses straight into the PC.
    always_comb begin
        next_pc = pc_plus4(pc_f);
        if (redirect_acc) begin
            next_pc = target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    assign fetch_word = (state == ST_HOLD) ? fbuf : imem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
            fbuf        <= 32'h0;
        end else begin
            if (fbuf_we) begin
                fbuf <= imem_rdata;
            end
            if (complete) begin
                pc_f       <= next_pc;
                pend_valid <= 1'b0;
            end else if (redirect_acc) begin
                pend_target <= target;
                pend_valid  <= 1'b1;
            end
        end
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (complete),
        .bubble   (bubble),
        .load_ir  (fetch_word),
        .load_pc4 (pc_plus4(pc_f)),
        .q        (if_id)
    );

    assign ir_d           = if_id.ir;
    assign pc4_d          = if_id.pc4;
    assign valid_d        = if_id.valid;
    assign imem_addr      = word_align(pc_f);
    assign dbg_state      = state;
    assign dbg_pend_valid = pend_valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register and instruction-fetch sequencer for the 5-stage MIPS pipeline.
- Issues instruction-memory requests through a variable-latency req/ack handshake.
- Loads the IF/ID pipeline register and supplies the D stage with ir_d and pc4_d.
- Consumes the D-stage next-PC result (npc_in plus redirect) and honours the architectural branch delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID as a bubble.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  from hazard unit; freezes the PC and IF/ID.
- redirect  in  1  the D-stage instruction is a jump/jr/jal or a taken branch; npc_in is valid.
- npc_in  in  32  control-transfer target computed in D.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_ack  in  1  rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction.
- pc_f  out  32  current fetch PC.
- ir_d  out  32  IF/ID instruction.
- pc4_d  out  32  IF/ID fetch PC + 4.
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (asynchronous, reset==0):
  - pc_f=RESET_PC, ir_d=NOP_INSTR, pc4_d=RESET_PC, valid_d=0.
  - imem_req=0, state=IDLE, pend_valid=0, pend_target=0, fbuf=0.
- States: IDLE, WAIT, HOLD.
- IDLE: lasts exactly one cycle after reset release, then goes to WAIT. imem_req=0.
- WAIT: imem_req=1 and imem_addr=pc_f. The address is held stable until imem_ack.
  - ack && !stall:
    - IF/ID <= {imem_rdata, pc_f+4, 1}.
    - pc_f <= next_pc.
    - Stay in WAIT. The new request is issued the next cycle (back-to-back, 1 instr/cycle at zero-wait memory).
  - ack && stall:
    - fbuf <= imem_rdata.
    - IF/ID unchanged.
    - Go to HOLD with imem_req=0.
  - !ack && !stall: IF/ID <= {NOP_INSTR, pc4_d, 0} (bubble). pc_f unchanged.
  - !ack && stall: IF/ID unchanged.
- HOLD: imem_req=0, IF/ID unchanged while stall.
  - On !stall: IF/ID <= {fbuf, pc_f+4, 1}, pc_f <= next_pc, go to WAIT.
- Redirect acceptance:
  - A redirect is accepted only when redirect && valid_d && !stall.
  - A redirect seen while stalled is ignored; it is re-presented the cycle D advances.
- Delay slot: when a redirect is accepted, the fetch in progress (or completing) is the delay slot. It is always delivered to IF/ID.
- next_pc, evaluated at fetch completion:
  - accepted redirect in the same cycle: {npc_in[31:2],2'b00} (bypass).
  - else pend_valid: pend_target.
  - else pc_f+4.
  - pend_valid is cleared at completion.
- Redirect accepted without fetch completion in the same cycle: pend_target <= {npc_in[31:2],2'b00}, pend_valid <= 1.
- Accepted redirect while pend_valid=1: cannot occur (D only sees bubbles until the delay slot arrives). The bench asserts this. The RTL overwrites pend_target.
- Arithmetic: pc+4 is a 32-bit add with wrap at 2^32. imem_addr[1:0] is always 00.
- The HOLD-to-WAIT transition takes one cycle; the next request starts the cycle after stall drops.

Decomposition:
- Shared pipeline package holds:
  - RESET_PC and NOP_INSTR constants.
  - The state encoding localparams (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2), reused by the hazard unit for debug.
- One natural sub-module: if_id_reg. It holds the ir/pc4/valid register with load, bubble and hold controls, and async active-low reset.
- Next-PC selection and the FSM stay in fetch_stage.

Test Plan:
- Reset and straight-line fetch:
  - Stimulus: release reset; memory always acks same cycle, rdata=addr.
  - Response: req rises 1 cycle after release with addr 0x3000. ir_d = 0x3000, 0x3004, 0x3008 on consecutive cycles; pc4_d = ir_d+4; valid_d=1.
- Redirect coincident with ack:
  - Stimulus: D holds j at 0x3000 (valid_d=1), redirect=1, npc_in=0x3400, ack for 0x3004.
  - Response: ir_d gets delay slot 0x3004, next imem_addr=0x3400.
- Pending redirect:
  - Stimulus: redirect with npc_in=0x3803 while ack delayed 3 cycles.
  - Response: valid_d=0 bubbles for 3 cycles, delay-slot instruction delivered, then imem_addr=0x3800 (low bits masked).
- Stall during ack:
  - Stimulus: stall=1 on the ack cycle, held 2 more cycles.
  - Response: state HOLD, req=0, IF/ID frozen. On release, fbuf loads into ir_d, and the next req occurs 1 cycle later at pc+4.
- Stall masks redirect:
  - Stimulus: redirect=1 with stall=1 for 2 cycles, npc_in garbage.
  - Response: no pend capture. Only the value presented when stall drops is used.
- Reset mid-WAIT:
  - Stimulus: assert reset while req outstanding with pend_valid=1.
  - Response: immediately req=0, pc_f=0x3000, valid_d=0, pend cleared. Refetch from 0x3000 after release.
